exibe_sequencia: RTL

EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

---
 rtl/exibe_sequencia.sv | 108 ++++++++++
 1 files changed

// File: rtl/exibe_sequencia.sv
// Shows RAM elements 0..rodada one at a time on one-hot LEDs, each lit then followed by a dark gap.
// Optional abort input is enabled by defining EXIBE_SEQUENCIA_ABORTA_EN.
module exibe_sequencia #(
  parameter int CICLOS_ACESO   = 10000,
  parameter int CICLOS_APAGADO = 2500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] rodada,
  input  logic [3:0] dado_mem,
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
  input  logic       abortar,
`endif
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       ocupado,
  output logic       pronto
);

  localparam int MAIOR   = (CICLOS_ACESO > CICLOS_APAGADO) ? CICLOS_ACESO : CICLOS_APAGADO;
  localparam int LARGURA = $clog2(MAIOR) + 1;
  localparam logic [LARGURA-1:0] ULTIMO_ACESO   = LARGURA'(CICLOS_ACESO - 1);
  localparam logic [LARGURA-1:0] ULTIMO_APAGADO = LARGURA'(CICLOS_APAGADO - 1);

  typedef enum logic [2:0] {
    OCIOSO,
    LE,
    ACESO,
    APAGADO,
    FIM
  } estado_t;

  estado_t            estado;
  estado_t            proximo;
  logic [LARGURA-1:0] contador;
  logic [3:0]         rodada_reg;
  logic               carrega;
  logic               avanca;
  logic               aborta;

  // LE exists to give the synchronous RAM one cycle to present dado_mem for the new address.
  always_comb begin
    proximo = estado;
    carrega = 1'b0;
    avanca  = 1'b0;
    aborta  = 1'b0;
`ifdef EXIBE_SEQUENCIA_ABORTA_EN
    aborta  = abortar && (estado != OCIOSO);
`endif
    case (estado)
      OCIOSO: begin
        if (iniciar) begin
          proximo = LE;
          carrega = 1'b1;
        end
      end
      LE: proximo = ACESO;
      ACESO: begin
        if (contador == ULTIMO_ACESO) proximo = APAGADO;
      end
      APAGADO: begin
        if (contador == ULTIMO_APAGADO) begin
          if (endereco == rodada_reg) begin
            proximo = FIM;
          end else begin
            proximo = LE;
            avanca  = 1'b1;
          end
        end
      end
      FIM:     proximo = OCIOSO;
      default: proximo = OCIOSO;
    endcase
    if (aborta) begin
      proximo = OCIOSO;
      carrega = 1'b0;
      avanca  = 1'b0;
    end
  end

  always_comb begin
    leds    = (estado == ACESO) ? dado_mem : 4'd0;
    ocupado = (estado != OCIOSO);
    pronto  = (estado == FIM);
  end

  // One shared duration counter, restarted whenever the state changes.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado     <= OCIOSO;
      contador   <= '0;
      endereco   <= 4'd0;
      rodada_reg <= 4'd0;
    end else begin
      estado <= proximo;
      if ((proximo != estado) || (estado == OCIOSO)) contador <= '0;
      else                                           contador <= contador + 1'b1;
      if (carrega) begin
        rodada_reg <= rodada;
        endereco   <= 4'd0;
      end else if (avanca) begin
        endereco <= endereco + 4'd1;
      end
    end
  end

endmodule
